apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_master_pkg.sv | 24 ++
 rtl/apb_timeout_cnt.sv | 32 +++
 rtl/apb_cmd_master.sv | 123 ++++++++++++
 tb/tb_apb_cmd_master.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types and helpers for the APB command master: FSM encoding,
// timeout counter sizing and the response status flags.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETUP  = 2'b01,
        ST_ACCESS = 2'b10,
        ST_RESP   = 2'b11
    } apb_state_e;

    typedef struct packed {
        logic err;
        logic timeout;
    } apb_rsp_t;

    // Wide enough to hold TIMEOUT_CYCLES itself; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned timeout_cycles);
        int unsigned w;
        w = $clog2(timeout_cycles + 1);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS-phase wait counter; terminal flags the last wait cycle allowed
// before the transfer is abandoned. TIMEOUT_CYCLES of 0 never terminates.
module apb_timeout_cnt
    import apb_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic p_clk,
    input  logic p_rst_n,
    input  logic clr,
    input  logic en,
    output logic terminal
);

    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign terminal = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(LAST));

endmodule

// File: rtl/apb_cmd_master.sv
// Single-outstanding APB master: accepts a command, runs one SETUP/ACCESS
// transfer with optional wait timeout, and holds the response until taken.
module apb_cmd_master
    import apb_master_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned STRB_WIDTH     = APB_DATA_WIDTH / 8
) (
    input  logic                      p_clk,
    input  logic                      p_rst_n,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
    input  logic [STRB_WIDTH-1:0]     cmd_strb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,

    output logic [APB_ADDR_WIDTH-1:0] paddr,
    output logic [2:0]                pprot,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic [STRB_WIDTH-1:0]     pstrb,
    input  logic                      pready,
    input  logic [APB_DATA_WIDTH-1:0] prdata,
    input  logic                      pslverr
);

    apb_state_e                state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q;
    logic                      pwrite_q;
    logic [APB_DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0]     pstrb_q;
    logic [APB_DATA_WIDTH-1:0] rsp_rdata_q;
    apb_rsp_t                  rsp_q;
    logic                      tmo_terminal;
    logic                      in_access;

    assign in_access = (state_q == ST_ACCESS);

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .p_clk    (p_clk),
        .p_rst_n  (p_rst_n),
        .clr      (state_q == ST_SETUP),
        .en       (in_access && !pready),
        .terminal (tmo_terminal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cmd_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready || tmo_terminal) state_d = ST_RESP;
            ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request fields are frozen at acceptance so they stay constant through ACCESS.
    always_ff @(posedge p_clk or negedge p_rst_n) begin
        if (!p_rst_n) begin
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_q       <= '0;
        end else begin
            if (state_q == ST_IDLE && cmd_valid) begin
                paddr_q  <= cmd_addr & ~APB_ADDR_WIDTH'(3);
                pwrite_q <= cmd_write;
                pwdata_q <= cmd_wdata;
                pstrb_q  <= cmd_write ? cmd_strb : '0;
            end
            // A ready completer on the last allowed wait cycle beats the timeout.
            if (in_access) begin
                if (pready) begin
                    rsp_rdata_q <= pwrite_q ? '0 : prdata;
                    rsp_q       <= '{err: pslverr, timeout: 1'b0};
                end else if (tmo_terminal) begin
                    rsp_rdata_q <= '0;
                    rsp_q       <= '{err: 1'b1, timeout: 1'b1};
                end
            end
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_q.err;
    assign rsp_timeout = rsp_q.timeout;

    assign psel        = (state_q == ST_SETUP) || in_access;
    assign penable     = in_access;
    assign paddr       = paddr_q;
    assign pprot       = 3'b000;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign pstrb       = pstrb_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with a response scoreboard.
module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
        logic          tmo;
    } exp_t;

    logic          p_clk = 1'b0;
    logic          p_rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic [2:0]    pprot;
    logic          psel, penable, pwrite, pready, pslverr;
    logic [DW-1:0] pwdata, prdata;
    logic [SW-1:0] pstrb;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;

    always #5 p_clk = ~p_clk;

    apb_cmd_master #(
        .APB_ADDR_WIDTH (AW),
        .APB_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .p_clk       (p_clk),
        .p_rst_n     (p_rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_strb    (cmd_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .paddr       (paddr),
        .pprot       (pprot),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pready      (pready),
        .prdata      (prdata),
        .pslverr     (pslverr)
    );

    task automatic step();
        @(posedge p_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] rdata, input logic err, input logic tmo);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.tmo   = tmo;
        sb.push_back(e);
    endtask

    task automatic check_rsp(input string tag);
        exp_t e;
        check({tag, "_pending"}, 64'(sb.size() > 0), 64'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
        check({tag, "_err"},   64'(rsp_err),   64'(e.err));
        check({tag, "_tmo"},   64'(rsp_timeout), 64'(e.tmo));
    endtask

    task automatic issue(input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [SW-1:0] strb);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_strb  = strb;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pen_cnt;
        exp_t e;
        logic [AW-1:0] addr_hold;

        p_rst_n   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_strb  = '0;
        rsp_ready = 1'b1;
        pready    = 1'b0;
        pslverr   = 1'b0;
        prdata    = 32'hDEAD_BEEF;

        // Reset state
        step(); step();
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_pstrb", 64'(pstrb), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_tmo", 64'(rsp_timeout), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        p_rst_n = 1'b1;
        step();
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_pprot", 64'(pprot), 64'd0);

        // Write, zero wait states
        issue(1'b1, 32'h0011_0004, 32'h0003_3333, 4'hF);
        pready = 1'b1;
        step();
        cmd_valid = 1'b0;
        push_exp(32'h0, 1'b0, 1'b0);
        check("wr_setup_psel", 64'(psel), 64'd1);
        check("wr_setup_penable", 64'(penable), 64'd0);
        check("wr_setup_cmd_ready", 64'(cmd_ready), 64'd0);
        check("wr_paddr", 64'(paddr), 64'h0011_0004);
        check("wr_pwrite", 64'(pwrite), 64'd1);
        check("wr_pwdata", 64'(pwdata), 64'h0003_3333);
        check("wr_pstrb", 64'(pstrb), 64'hF);
        step();
        check("wr_access_psel", 64'(psel), 64'd1);
        check("wr_access_penable", 64'(penable), 64'd1);
        step();
        pready = 1'b0;
        check("wr_resp_psel", 64'(psel), 64'd0);
        check("wr_resp_penable", 64'(penable), 64'd0);
        check_rsp("wr_rsp");
        step();
        check("wr_back_idle", 64'(cmd_ready), 64'd1);

        // Read, three wait states; completion lands on the timeout-terminal cycle
        issue(1'b0, 32'h0011_000B, 32'h1234_5678, 4'hF);
        step();
        cmd_valid = 1'b0;
        push_exp(32'h0000_00FF, 1'b0, 1'b0);
        check("rd_paddr_align", 64'(paddr), 64'h0011_0008);
        check("rd_pstrb_zero", 64'(pstrb), 64'd0);
        check("rd_pwrite", 64'(pwrite), 64'd0);
        step();
        pen_cnt = 0;
        for (int i = 0; i < 12 && penable; i++) begin
            pen_cnt++;
            check("rd_paddr_hold", 64'(paddr), 64'h0011_0008);
            if (pen_cnt == 4) begin
                pready = 1'b1;
                prdata = 32'h0000_00FF;
            end
            step();
        end
        pready = 1'b0;
        prdata = 32'hDEAD_BEEF;
        check("rd_penable_cycles", 64'(pen_cnt), 64'd4);
        check("rd_resp_psel", 64'(psel), 64'd0);
        check_rsp("rd_rsp");
        step();

        // Write completing with pslverr; read data must not leak into a write response
        issue(1'b1, 32'h0000_0020, 32'hCAFE_0001, 4'h3);
        pready  = 1'b1;
        pslverr = 1'b1;
        prdata  = 32'h0000_1234;
        step();
        cmd_valid = 1'b0;
        push_exp(32'h0, 1'b1, 1'b0);
        check("err_pstrb", 64'(pstrb), 64'h3);
        step();
        step();
        pready  = 1'b0;
        pslverr = 1'b0;
        check_rsp("err_rsp");
        step();

        // Timeout: completer never ready
        issue(1'b0, 32'h0000_0040, 32'h0, 4'h0);
        prdata = 32'h5555_AAAA;
        step();
        cmd_valid = 1'b0;
        push_exp(32'h0, 1'b1, 1'b1);
        step();
        pen_cnt = 0;
        for (int i = 0; i < 20 && penable; i++) begin
            pen_cnt++;
            step();
        end
        check("tmo_access_cycles", 64'(pen_cnt), 64'd4);
        check("tmo_psel", 64'(psel), 64'd0);
        check_rsp("tmo_rsp");
        step();

        // Response backpressure with a new command waiting
        rsp_ready = 1'b0;
        issue(1'b1, 32'h0011_0010, 32'h0000_A5A5, 4'hF);
        pready = 1'b1;
        prdata = 32'h0000_9999;
        step();
        cmd_valid = 1'b0;
        push_exp(32'h0, 1'b0, 1'b0);
        step();
        step();
        pready = 1'b0;
        issue(1'b0, 32'h0011_0014, 32'h0, 4'h0);
        check("bp_pending", 64'(sb.size() > 0), 64'd1);
        e = sb.pop_front();
        addr_hold = paddr;
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            check("bp_rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("bp_rsp_err", 64'(rsp_err), 64'(e.err));
            check("bp_rsp_tmo", 64'(rsp_timeout), 64'(e.tmo));
            check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
            check("bp_psel", 64'(psel), 64'd0);
            check("bp_paddr", 64'(paddr), 64'h0011_0010);
            step();
        end
        rsp_ready = 1'b1;
        push_exp(32'h0000_0077, 1'b0, 1'b0);
        step();
        check("bp_release_idle", 64'(cmd_ready), 64'd1);
        check("bp_release_valid", 64'(rsp_valid), 64'd0);
        step();
        cmd_valid = 1'b0;
        check("bp_next_psel", 64'(psel), 64'd1);
        check("bp_next_paddr", 64'(paddr), 64'h0011_0014);
        pready = 1'b1;
        prdata = 32'h0000_0077;
        step();
        step();
        pready = 1'b0;
        check_rsp("bp_next_rsp");
        step();

        // Reset in the middle of ACCESS
        issue(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        step();
        cmd_valid = 1'b0;
        step();
        check("ar_in_access", 64'(penable), 64'd1);
        #2;
        p_rst_n = 1'b0;
        #1;
        check("ar_psel_async", 64'(psel), 64'd0);
        check("ar_penable_async", 64'(penable), 64'd0);
        check("ar_rsp_valid", 64'(rsp_valid), 64'd0);
        step();
        step();
        p_rst_n = 1'b1;
        step();
        check("ar_cmd_ready", 64'(cmd_ready), 64'd1);
        for (int i = 0; i < 3; i++) begin
            check("ar_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
